// File: rtl/ballot_frontend.sv
// Voting-booth front end: synchronised, debounced buttons feed a one-ballot-per-session FSM.
// Optional ARMED-state timeout is enabled by defining BALLOT_TIMEOUT_EN.
module ballot_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_cand,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    input  logic       session_en,
    output logic [3:0] vote_onehot,
    output logic       vote_valid,
    input  logic       vote_ready,
    output logic       busy,
    output logic       err_multi,
    output logic       timeout,
    output logic [7:0] vote_count
);

    typedef enum logic [2:0] {IDLE, SELECT, ARMED, SEND, DONE} state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [5:0] raw;
    logic [5:0] sync_p0, sync_p1;
    logic [5:0] deb, deb_prev;
    logic [7:0] db_cnt [6];

    assign raw = {btn_cancel, btn_confirm, btn_cand};

    // Stage p0/p1: two-flop synchroniser, then per-input debounce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0  <= raw;
            sync_p1  <= sync_p0;
            deb_prev <= deb;
            for (int i = 0; i < 6; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    logic [5:0] rise;
    logic [3:0] cand;
    logic       cand_rise, confirm_rise, cancel_rise;

    assign rise         = deb & ~deb_prev;
    assign cand         = deb[3:0];
    assign cand_rise    = |rise[3:0];
    assign confirm_rise = rise[4];
    assign cancel_rise  = rise[5];

    state_t     state;
    logic [3:0] latch;

`ifdef BALLOT_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
    logic        tmo_pulse;
    assign timeout = tmo_pulse;
`else
    assign timeout = 1'b0;
`endif

    // Stage p2: session FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            latch       <= '0;
            vote_count  <= '0;
            vote_valid  <= 1'b0;
            vote_onehot <= '0;
            busy        <= 1'b0;
            err_multi   <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            tmo_cnt     <= '0;
            tmo_pulse   <= 1'b0;
`endif
        end else begin
            err_multi <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            tmo_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (session_en) begin
                        state <= SELECT;
                        busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (!session_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        latch <= '0;
                    end else if (cand_rise) begin
                        if (is_onehot(cand)) begin
                            latch <= cand;
                            state <= ARMED;
`ifdef BALLOT_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            err_multi <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (!session_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        latch <= '0;
                    end else if (cancel_rise) begin
                        state <= SELECT;
                        latch <= '0;
                    end else if (confirm_rise) begin
                        state       <= SEND;
                        vote_valid  <= 1'b1;
                        vote_onehot <= latch;
                    end else if (cand_rise && is_onehot(cand)) begin
                        latch <= cand;
`ifdef BALLOT_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
                        if (cand_rise) err_multi <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
                        if (tmo_cnt == TMO_LAST) begin
                            state     <= SELECT;
                            latch     <= '0;
                            tmo_pulse <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
`endif
                    end
                end
                SEND: begin
                    if (vote_ready) begin
                        state       <= DONE;
                        vote_valid  <= 1'b0;
                        vote_onehot <= '0;
                        latch       <= '0;
                        vote_count  <= sat_inc(vote_count);
                    end
                end
                DONE: begin
                    if (!session_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_frontend.sv
// Bench for ballot_frontend: directed scenarios plus random stimulus against a behavioural model.
// Define BALLOT_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_ballot_frontend;

    localparam int DB  = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_cand;
    logic       btn_confirm, btn_cancel, session_en, vote_ready;
    logic [3:0] vote_onehot;
    logic       vote_valid, busy, err_multi, timeout;
    logic [7:0] vote_count;

    ballot_frontend #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .btn_cand(btn_cand), .btn_confirm(btn_confirm),
        .btn_cancel(btn_cancel), .session_en(session_en), .vote_onehot(vote_onehot),
        .vote_valid(vote_valid), .vote_ready(vote_ready), .busy(busy),
        .err_multi(err_multi), .timeout(timeout), .vote_count(vote_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_seen = 0, valid_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state codes 0 idle, 1 select, 2 armed, 3 send, 4 done
    int         m_state;
    logic [3:0] m_latch;
    logic [7:0] m_count;
    logic       m_err, m_tmo;
    int         m_tcnt;
    logic [5:0] m_deb, m_pdeb;
    logic [5:0] hist [DB+2];

    task automatic model_reset();
        m_state = 0; m_latch = 0; m_count = 0; m_err = 0; m_tmo = 0; m_tcnt = 0;
        m_deb = 0; m_pdeb = 0;
        for (int j = 0; j < DB + 2; j++) hist[j] = 0;
    endtask

    task automatic model_step();
        logic [5:0] r;
        logic [3:0] c;
        logic       crise, one, diff;
        r     = m_deb & ~m_pdeb;
        c     = m_deb[3:0];
        crise = |r[3:0];
        one   = ($countones(c) == 1);
        m_err = 0;
        m_tmo = 0;
        case (m_state)
            0: if (session_en) m_state = 1;
            1: begin
                if (!session_en) begin m_state = 0; m_latch = 0; end
                else if (crise) begin
                    if (one) begin m_latch = c; m_state = 2; m_tcnt = 0; end
                    else m_err = 1;
                end
            end
            2: begin
                if (!session_en) begin m_state = 0; m_latch = 0; end
                else if (r[5]) begin m_state = 1; m_latch = 0; end
                else if (r[4]) m_state = 3;
                else if (crise && one) begin m_latch = c; m_tcnt = 0; end
                else begin
                    if (crise) m_err = 1;
`ifdef BALLOT_TIMEOUT_EN
                    m_tcnt++;
                    if (m_tcnt == TMO) begin m_state = 1; m_latch = 0; m_tmo = 1; end
`endif
                end
            end
            3: if (vote_ready) begin
                m_count = (m_count == 8'd255) ? 8'd255 : m_count + 8'd1;
                m_latch = 0;
                m_state = 4;
            end
            default: if (!session_en) m_state = 0;
        endcase
        // A level changes once the last DB synchronised samples all disagree with it
        m_pdeb = m_deb;
        for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = {btn_cancel, btn_confirm, btn_cand};
        for (int b = 0; b < 6; b++) begin
            diff = 1;
            for (int j = 2; j <= DB + 1; j++) if (hist[j][b] == m_deb[b]) diff = 0;
            if (diff) m_deb[b] = ~m_deb[b];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("outputs", {vote_valid, vote_onehot, busy, err_multi, timeout, vote_count},
                  {(m_state == 3), ((m_state == 3) ? m_latch : 4'd0), (m_state != 0), m_err, m_tmo, m_count});
            if (err_multi) err_seen++;
            if (vote_valid) valid_seen++;
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int bound, output int lat);
        lat = 0;
        while (!vote_valid && lat < bound) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_ballot(input logic [3:0] c);
        int lat;
        session_en = 1; btn_cand = c;
        cycles(DB + 4);
        btn_cand = 0; btn_confirm = 1; vote_ready = 1;
        wait_valid(30, lat);
        check("ballot_valid", vote_valid, 1);
        cycles(1);
        btn_confirm = 0; vote_ready = 0; session_en = 0;
        cycles(DB + 4);
    endtask

    initial begin
        int lat, e0, v0, n;
        logic saw;
        rst = 1; btn_cand = 0; btn_confirm = 0; btn_cancel = 0; session_en = 0; vote_ready = 0;
        cycles(3);
        check("reset_outputs", {vote_valid, vote_onehot, busy, err_multi, timeout, vote_count}, 0);
        rst = 0;

        // Single ballot for candidate 2
        session_en = 1; cycles(2);
        check("busy_select", busy, 1);
        btn_cand = 4'b0100; cycles(10); btn_cand = 0; cycles(8);
        btn_confirm = 1; vote_ready = 1;
        wait_valid(50, lat);
        check("confirm_latency", lat, 7);
        check("onehot_0100", vote_onehot, 4'b0100);
        cycles(1);
        check("valid_one_clock", vote_valid, 0);
        check("count_one", vote_count, 1);
        check("busy_done", busy, 1);
        btn_confirm = 0; vote_ready = 0; cycles(8);
        session_en = 0; cycles(2);
        check("busy_idle", busy, 0);

        // Short glitch is ignored
        session_en = 1; cycles(2);
        e0 = err_seen; v0 = valid_seen;
        btn_cand = 4'b0001; cycles(3); btn_cand = 0; cycles(12);
        check("glitch_no_err", err_seen - e0, 0);
        btn_confirm = 1; cycles(12); btn_confirm = 0; cycles(8);
        check("glitch_no_latch", valid_seen - v0, 0);

        // Multi-bit press, then valid ballot held under backpressure
        e0 = err_seen;
        btn_cand = 4'b0011; cycles(10); btn_cand = 0; cycles(8);
        check("multi_err_pulse", err_seen - e0, 1);
        btn_cand = 4'b0010; cycles(10); btn_cand = 0; cycles(8);
        btn_confirm = 1;
        wait_valid(50, lat);
        check("confirm_latency_bp", lat, 7);
        for (int k = 0; k < 5; k++) begin
            check("held_valid", {vote_valid, vote_onehot, vote_count}, {1'b1, 4'b0010, 8'd1});
            if (k == 4) vote_ready = 1;
            @(negedge clk);
        end
        check("transfer_clk6", {vote_valid, vote_count}, {1'b0, 8'd2});
        btn_confirm = 0; vote_ready = 0; cycles(8);
        session_en = 0; cycles(2);

        // Cancel beats confirm
        session_en = 1; cycles(1);
        btn_cand = 4'b0001; cycles(10); btn_cand = 0; cycles(8);
        v0 = valid_seen;
        btn_confirm = 1; btn_cancel = 1; cycles(12);
        btn_confirm = 0; btn_cancel = 0; cycles(8);
        check("cancel_priority", valid_seen - v0, 0);
        btn_confirm = 1; cycles(12); btn_confirm = 0; cycles(8);
        check("cancel_to_select", valid_seen - v0, 0);
        check("cancel_busy", busy, 1);

        // ARMED timeout behaviour
        btn_cand = 4'b1000;
        n = 0; saw = 0;
        while (n < 107) begin
            @(negedge clk);
            n++;
            if (n == 10) btn_cand = 0;
            if (timeout) begin saw = 1; break; end
        end
`ifdef BALLOT_TIMEOUT_EN
        check("timeout_seen", saw, 1);
        check("timeout_clock", n, 27);
        v0 = valid_seen;
        btn_confirm = 1; cycles(12); btn_confirm = 0; cycles(8);
        check("timeout_to_select", valid_seen - v0, 0);
`else
        check("no_timeout", saw, 0);
        btn_confirm = 1; vote_ready = 1;
        wait_valid(50, lat);
        check("still_armed", lat, 7);
        check("armed_onehot", vote_onehot, 4'b1000);
        cycles(1);
        btn_confirm = 0; vote_ready = 0; cycles(8);
`endif
        session_en = 0; cycles(4);

        // Random stimulus checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) btn_cand = btn_cand ^ (4'd1 << $urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) btn_confirm = ~btn_confirm;
            if ($urandom_range(0, 15) == 0) btn_cancel = ~btn_cancel;
            if ($urandom_range(0, 59) == 0) session_en = ~session_en;
            vote_ready = ($urandom_range(0, 2) == 0);
        end

        // Saturating count over 256 ballots
        btn_cand = 0; btn_confirm = 0; btn_cancel = 0; session_en = 0; vote_ready = 0;
        rst = 1; cycles(2); rst = 0; cycles(1);
        check("count_cleared", vote_count, 0);
        for (int i = 0; i < 255; i++) do_ballot(4'd1 << (i % 4));
        check("count_255", vote_count, 255);
        do_ballot(4'b0100);
        check("count_saturated", vote_count, 255);

        // Reset in the middle of SEND
        session_en = 1; btn_cand = 4'b0010; cycles(DB + 4);
        btn_cand = 0; btn_confirm = 1;
        wait_valid(30, lat);
        check("send_before_rst", vote_valid, 1);
        #2 rst = 1;
        #1;
        check("rst_drops_valid", vote_valid, 0);
        check("rst_count_zero", vote_count, 0);
        btn_confirm = 0; btn_cand = 4'b0001;
        @(negedge clk); cycles(2);
        rst = 0;
        cycles(10);
        btn_confirm = 1; vote_ready = 1;
        wait_valid(30, lat);
        check("held_after_rst", {vote_valid, vote_onehot}, {1'b1, 4'b0001});
        cycles(1);
        check("count_after_rst", vote_count, 1);
        btn_cand = 0; btn_confirm = 0; vote_ready = 0; session_en = 0;
        cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
